// File: rtl/veldt_ram_responder_if.sv
// Request/response bundle between the Veldt core (master) and its data-memory responder (slave).
// The 97-bit ram_in is the core's packed request word; the rest is the response side.
interface veldt_ram_responder_if;
    logic [96:0] ram_in;
    logic        ram_ready;
    logic [31:0] ram_out;
    logic        ram_valid;
    logic        ram_err;

    modport master (output ram_in, input ram_ready, ram_out, ram_valid, ram_err);
    modport slave  (input ram_in, output ram_ready, ram_out, ram_valid, ram_err);
endinterface

// File: rtl/veldt_ram_responder.sv
// Word-addressed data RAM with byte mask and one outstanding request; response LATENCY cycles after accept.
// ram_ready only in IDLE, so req is held off while busy; VELDT_RAM_MISALIGN_TRAP_EN turns addr[1:0]!=0 into an error.
module veldt_ram_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    veldt_ram_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        write;
        logic [26:0] rsvd;
    } req_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    req_t        req_in;
    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [1:0]  rst_sync;
    logic        rst_int_n;
    logic        accept;
    logic [31:0] addr_q, wdata_q, out_q, rdata;
    logic [3:0]  mask_q;
    logic        write_q;
    logic        err;
    logic [AW-1:0] idx;
    logic [31:0] mem [DEPTH];

    assign req_in = bus.ram_in;

    // Assert asynchronously, release on a clock edge so the FSM never leaves reset mid-cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    assign accept = req_in.req && (state == IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (accept) begin
                state_nxt = (LATENCY == 1) ? RESP : WAIT;
                cnt_nxt   = 4'(LATENCY - 1);
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt_nxt == 4'd0) state_nxt = RESP;
            end
            RESP: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            write_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                addr_q  <= req_in.addr;
                wdata_q <= req_in.wdata;
                mask_q  <= req_in.mask;
                write_q <= req_in.write;
            end
            if (state == RESP && !write_q) out_q <= rdata;
        end
    end

    assign idx = addr_q[AW+1:2];

`ifdef VELDT_RAM_MISALIGN_TRAP_EN
    assign err = (addr_q[31:AW+2] != '0) || (addr_q[1:0] != 2'b00);
`else
    assign err = (addr_q[31:AW+2] != '0);
`endif

    logic unused_lsb;
    assign unused_lsb = ^addr_q[1:0];

    assign rdata = err ? 32'd0 : mem[idx];

    // Writes commit as RESP ends, before any later accept, so read-after-write sees new data.
    always_ff @(posedge clock) begin
        if (state == RESP && write_q && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (mask_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign bus.ram_ready = (state == IDLE);
    assign bus.ram_valid = (state == RESP);
    assign bus.ram_err   = (state == RESP) && err;
    assign bus.ram_out   = (state == RESP && !write_q) ? rdata : out_q;

    always @(posedge clock) begin
        if (rst_int_n) assert (!(accept && (req_in.rsvd != '0)));
    end
endmodule

// File: tb/tb_veldt_ram_responder.sv
// Directed plus randomized checks of veldt_ram_responder at LATENCY=3 (u3) and LATENCY=4 (u4) against a word-array model.
module tb_veldt_ram_responder;
    logic clk = 1'b0;
    logic rst3_n = 1'b0;
    logic rst4_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    veldt_ram_responder_if if3 ();
    veldt_ram_responder_if if4 ();

    veldt_ram_responder #(.DEPTH(1024), .LATENCY(3)) u3 (.clock(clk), .reset_n(rst3_n), .bus(if3));
    veldt_ram_responder #(.DEPTH(1024), .LATENCY(4)) u4 (.clock(clk), .reset_n(rst4_n), .bus(if4));

    logic [31:0] mdl [16];
    logic [31:0] last3 = 32'd0;
    logic [31:0] last4 = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic logic vld(input int sel);
        return (sel == 3) ? if3.ram_valid : if4.ram_valid;
    endfunction

    function automatic logic rdy(input int sel);
        return (sel == 3) ? if3.ram_ready : if4.ram_ready;
    endfunction

    task automatic drive(input int sel, input logic [96:0] v);
        if (sel == 3) if3.ram_in = v;
        else          if4.ram_in = v;
    endtask

    // One request/response; checks latency, error flag, ram_out and that valid is a single pulse.
    task automatic do_op(input int sel, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask, input logic wr, input logic exp_err,
                         input logic [31:0] exp_dat, input int exp_lat, input string tag);
        int g;
        int lat;
        logic [31:0] rd;
        logic er;
        g = 0;
        while (!rdy(sel) && g < 50) begin @(negedge clk); g++; end
        chk({tag, "_ready"}, 32'(rdy(sel)), 32'd1);
        drive(sel, {1'b1, addr, wdata, mask, wr, 27'd0});
        @(negedge clk);
        drive(sel, 97'd0);
        lat = 1;
        while (!vld(sel) && lat < 50) begin @(negedge clk); lat++; end
        rd = (sel == 3) ? if3.ram_out : if4.ram_out;
        er = (sel == 3) ? if3.ram_err : if4.ram_err;
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_err"}, 32'(er), 32'(exp_err));
        chk({tag, "_dat"}, rd, exp_dat);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(vld(sel)), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w, a, exp;
        logic [3:0]  m;
        logic        wr, oor;
        int          idx;
        logic        saw;

        if3.ram_in = 97'd0;
        if4.ram_in = 97'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(if3.ram_ready), 32'd1);
        chk("rst_valid", 32'(if3.ram_valid), 32'd0);
        chk("rst_out", if3.ram_out, 32'd0);
        chk("rst_err", 32'(if3.ram_err), 32'd0);
        rst3_n = 1'b1;
        rst4_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_ready", 32'(if3.ram_ready), 32'd1);
        chk("post_rst_valid", 32'(if4.ram_valid), 32'd0);

        do_op(3, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'd0, 3, "wr10");
        do_op(3, 32'h10, 32'd0, 4'h0, 1'b0, 1'b0, 32'hDEADBEEF, 3, "rd10");
        do_op(3, 32'h10, 32'h11223344, 4'b0101, 1'b1, 1'b0, 32'hDEADBEEF, 3, "wr10_mask");
        do_op(3, 32'h10, 32'd0, 4'hF, 1'b0, 1'b0, 32'hDE22BE44, 3, "rd10_mask");
        do_op(3, 32'h1000, 32'd0, 4'h0, 1'b0, 1'b1, 32'd0, 3, "rd_oor");
        do_op(3, 32'h0, 32'h0BADF00D, 4'hF, 1'b1, 1'b0, 32'd0, 3, "wr0");
        do_op(3, 32'h1000, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 32'd0, 3, "wr_oor");
        do_op(3, 32'h0, 32'd0, 4'h0, 1'b0, 1'b0, 32'h0BADF00D, 3, "rd0_after_oor");
        do_op(3, 32'h10, 32'd0, 4'h0, 1'b1, 1'b0, 32'h0BADF00D, 3, "wr10_nomask");
`ifdef VELDT_RAM_MISALIGN_TRAP_EN
        do_op(3, 32'h12, 32'd0, 4'h0, 1'b0, 1'b1, 32'd0, 3, "rd_misalign");
        last3 = 32'd0;
`else
        do_op(3, 32'h12, 32'd0, 4'h0, 1'b0, 1'b0, 32'hDE22BE44, 3, "rd_misalign");
        last3 = 32'hDE22BE44;
`endif

        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            do_op(3, 32'(i * 4), w, 4'hF, 1'b1, 1'b0, last3, 3, "rnd_init");
            mdl[i] = w;
        end
        for (int n = 0; n < 40; n++) begin
            idx = int'($urandom_range(0, 15));
            oor = ($urandom_range(0, 7) == 0);
            a   = {oor ? 20'($urandom_range(1, 20'hFFFFF)) : 20'd0, 10'(idx), 2'b00};
            wr  = 1'($urandom_range(0, 1));
            m   = 4'($urandom_range(0, 15));
            w   = $urandom;
            if (wr) begin
                do_op(3, a, w, m, 1'b1, oor, last3, 3, "rnd_wr");
                if (!oor) mdl[idx] = merge(mdl[idx], w, m);
            end else begin
                exp = oor ? 32'd0 : mdl[idx];
                do_op(3, a, w, m, 1'b0, oor, exp, 3, "rnd_rd");
                last3 = exp;
            end
        end

        do_op(4, 32'h20, 32'h12345678, 4'hF, 1'b1, 1'b0, last4, 4, "b_init");
        saw = 1'b0;
        while (!if4.ram_ready) @(negedge clk);
        if4.ram_in = {1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b1, 27'd0};
        @(negedge clk);
        if4.ram_in = 97'd0;
        saw = saw | if4.ram_valid;
        @(posedge clk);
        @(posedge clk);
        #1 rst4_n = 1'b0;
        repeat (2) begin @(negedge clk); saw = saw | if4.ram_valid; end
        rst4_n = 1'b1;
        chk("midrst_ready", 32'(if4.ram_ready), 32'd1);
        repeat (6) begin @(negedge clk); saw = saw | if4.ram_valid; end
        chk("midrst_no_valid", 32'(saw), 32'd0);
        do_op(4, 32'h20, 32'd0, 4'h0, 1'b0, 1'b0, 32'h12345678, 4, "midrst_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
